// File: rtl/alu_sched.sv
// Two-requester scheduler sharing one registered signed ALU; returns results over a valid/ready port.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_sched #(
    parameter int WIDTH       = 16,
    parameter int ARITH_WIDTH = 2 * WIDTH,
    parameter int LOGIC_WIDTH = WIDTH,
    parameter int SHIFT_WIDTH = WIDTH + 1,
    parameter int CMP_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*WIDTH-1:0]     req_a,
    input  logic [2*WIDTH-1:0]     req_b,
    input  logic [7:0]             req_func,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [ARITH_WIDTH-1:0] rsp_data,
    output logic                   rsp_carry,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [3:0]             alu_func,
    input  logic                   arith_flag,
    input  logic                   logic_flag,
    input  logic                   cmp_flag,
    input  logic                   shift_flag,
    input  logic                   carry_out,
    input  logic [ARITH_WIDTH-1:0] arith_out,
    input  logic [LOGIC_WIDTH-1:0] logic_out,
    input  logic [SHIFT_WIDTH-1:0] shift_out,
    input  logic [CMP_WIDTH-1:0]   cmp_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   id_q, id_d;
    logic [WIDTH-1:0]       alu_a_q, alu_a_d;
    logic [WIDTH-1:0]       alu_b_q, alu_b_d;
    logic [3:0]             alu_func_q, alu_func_d;
    logic [ARITH_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                   rsp_carry_q, rsp_carry_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [1:0]             grant;
    logic                   req_hs;
    logic                   sel_id;

`ifdef ALU_SCHED_RR_EN
    // Last requester granted; resets to 1 so requester 0 wins the first conflict.
    logic last_q, last_d;

    always_comb begin
        if (&req_valid) grant = last_q ? 2'b01 : 2'b10;
        else            grant = req_valid;
    end
`else
    always_comb begin
        grant = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
    end
`endif

    // Gating with rst keeps every output at 0 for the whole reset interval.
    assign req_ready = (state_q == IDLE && rst) ? grant : 2'b00;
    assign req_hs    = |(req_valid & req_ready);
    assign sel_id    = req_ready[1];

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        state_d     = state_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_func_d  = alu_func_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
`ifdef ALU_SCHED_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    alu_a_d    = sel_id ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                    alu_b_d    = sel_id ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                    alu_func_d = sel_id ? req_func[4 +: 4]      : req_func[0 +: 4];
                    id_d       = sel_id;
`ifdef ALU_SCHED_RR_EN
                    last_d     = sel_id;
`endif
                    state_d    = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                // The ALU result for the held operands is valid in this cycle.
                case (alu_func_q[3:2])
                    2'b00: begin
                        rsp_data_d  = arith_out;
                        rsp_carry_d = carry_out;
                        rsp_err_d   = ~arith_flag;
                    end
                    2'b01: begin
                        rsp_data_d  = ARITH_WIDTH'(logic_out);
                        rsp_carry_d = 1'b0;
                        rsp_err_d   = ~logic_flag;
                    end
                    2'b10: begin
                        rsp_data_d  = ARITH_WIDTH'(cmp_out);
                        rsp_carry_d = 1'b0;
                        rsp_err_d   = ~cmp_flag;
                    end
                    2'b11: begin
                        rsp_data_d  = ARITH_WIDTH'(shift_out);
                        rsp_carry_d = 1'b0;
                        rsp_err_d   = ~shift_flag;
                    end
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q        <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_func_q  <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef ALU_SCHED_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_func_q  <= alu_func_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
`ifdef ALU_SCHED_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_func  = alu_func_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: a small registered ALU model feeds the result buses,
// a vector table covers each unit, and hand-written sequences cover arbitration, stall and reset.
module tb_alu_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_func;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_err;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_func;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag, carry_out;
    logic [31:0] arith_out;
    logic [15:0] logic_out;
    logic [16:0] shift_out;
    logic [2:0]  cmp_out;

    logic        force_low;
    int          n_checks;
    int          n_fail;

    alu_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_func   (req_func),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag),
        .carry_out  (carry_out),
        .arith_out  (arith_out),
        .logic_out  (logic_out),
        .shift_out  (shift_out),
        .cmp_out    (cmp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: one registered stage from alu_a/alu_b/alu_func.
    logic signed [31:0] m_sa, m_sb;
    logic [16:0]        m_add, m_sub;
    logic [31:0]        m_arith;
    logic [15:0]        m_logic;
    logic [16:0]        m_shift;
    logic [2:0]         m_cmp;
    logic               m_carry;

    always_comb begin
        m_sa  = {{16{alu_a[15]}}, alu_a};
        m_sb  = {{16{alu_b[15]}}, alu_b};
        m_add = {1'b0, alu_a} + {1'b0, alu_b};
        m_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        case (alu_func[1:0])
            2'b00:   m_arith = m_sa + m_sb;
            2'b01:   m_arith = m_sa - m_sb;
            default: m_arith = m_sa * m_sb;
        endcase
        m_carry = m_add[16];
        if (alu_func == 4'b0001) m_carry = m_sub[16];
        if (alu_func[3:1] == 3'b001) m_carry = 1'b0;
        case (alu_func[1:0])
            2'b00:   m_logic = alu_a & alu_b;
            2'b01:   m_logic = alu_a | alu_b;
            2'b10:   m_logic = alu_a ^ alu_b;
            default: m_logic = ~alu_a;
        endcase
        m_cmp = {$signed(alu_a) < $signed(alu_b), alu_a == alu_b, $signed(alu_a) > $signed(alu_b)};
        case (alu_func[1:0])
            2'b00:   m_shift = {1'b0, alu_a} << alu_b[3:0];
            2'b01:   m_shift = {1'b0, alu_a >> alu_b[3:0]};
            default: m_shift = {alu_a[15], $signed(alu_a) >>> alu_b[3:0]};
        endcase
    end

    always @(posedge clk) begin
        arith_out <= m_arith;
        logic_out <= m_logic;
        shift_out <= m_shift;
        cmp_out   <= m_cmp;
        carry_out <= m_carry;
    end

    assign arith_flag = ~force_low;
    assign logic_flag = ~force_low;
    assign cmp_flag   = ~force_low;
    assign shift_flag = ~force_low;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  func;
        logic        flag_low;
        logic [31:0] data;
        logic        carry;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    task automatic do_op(input vec_t v);
        int n;
        force_low = v.flag_low;
        req_a     = v.id ? {v.a, ~v.a} : {~v.a, v.a};
        req_b     = v.id ? {v.b, ~v.b} : {~v.b, v.b};
        req_func  = v.id ? {v.func, ~v.func} : {~v.func, v.func};
        req_valid = v.id ? 2'b10 : 2'b01;
        #1;
        check("req_ready", 80'(req_ready), 80'(v.id ? 2'b10 : 2'b01));
        step();
        req_valid = 2'b00;
        check("alu_operands", 80'({alu_a, alu_b, alu_func}), 80'({v.a, v.b, v.func}));
        n = 0;
        while (!rsp_valid && n < 8) begin
            step();
            n++;
        end
        check("latency", 80'(n), 80'd2);
        check("rsp_id", 80'(rsp_id), 80'(v.id));
        check("rsp_data", 80'(rsp_data), 80'(v.data));
        check("rsp_carry", 80'(rsp_carry), 80'(v.carry));
        check("rsp_err", 80'(rsp_err), 80'(v.err));
        step();
        check("rsp_done", 80'(rsp_valid), 80'd0);
        force_low = 1'b0;
    endtask

    logic [1:0]  exp_g2;
    logic        exp_id2;
    logic [31:0] exp_d2;
    int          late_valid;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        force_low = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_a     = 32'h1234_5678;
        req_b     = 32'h9ABC_DEF0;
        req_func  = 8'h00;

        //                 id    a         b         func     fl    data            c     e
        vecs[0]  = '{1'b0, 16'h0003, 16'hFFFE, 4'b0000, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 16'h0005, 16'h0007, 4'b0001, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'hFFFD, 16'h0004, 4'b0010, 1'b0, 32'hFFFF_FFF4, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'hF0F0, 16'h0FFF, 4'b0100, 1'b0, 32'h0000_00F0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h1200, 16'h0034, 4'b0101, 1'b0, 32'h0000_1234, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 16'hAAAA, 16'hFFFF, 4'b0110, 1'b0, 32'h0000_5555, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'hFFFF, 16'h0001, 4'b1000, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 16'h1234, 16'h1234, 4'b1000, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 16'h8001, 16'h0001, 4'b1100, 1'b0, 32'h0001_0002, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 16'h8000, 16'h0004, 4'b1110, 1'b0, 32'h0001_F800, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h8000, 16'h0004, 4'b1101, 1'b0, 32'h0000_0800, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'h00FF, 16'h0000, 4'b0111, 1'b0, 32'h0000_FF00, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 16'h0001, 16'h0001, 4'b0000, 1'b1, 32'h0000_0002, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 16'hFFFF, 16'hFF00, 4'b0110, 1'b1, 32'h0000_00FF, 1'b0, 1'b1};

        // Reset state, with both requests already asserted.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {req_ready, rsp_valid, rsp_id, rsp_carry, rsp_err, rsp_data, alu_a, alu_b, alu_func,
               6'b0}, 80'd0);
        req_valid = 2'b00;
        rst = 1'b1;
        step();

        for (int i = 0; i < 14; i++) do_op(vecs[i]);

        // Two back-to-back operations with both requesters pending.
        do_reset();
        req_a     = {16'h0020, 16'h0010};
        req_b     = {16'h0002, 16'h0001};
        req_func  = {4'b0001, 4'b0000};
        req_valid = 2'b11;
        #1;
        check("conflict_grant1", 80'(req_ready), 80'(2'b01));
        step();
        check("exec_no_ready", 80'(req_ready), 80'd0);
        step();
        step();
        check("conflict_rsp1", 80'({rsp_valid, rsp_id, rsp_data}), 80'({1'b1, 1'b0, 32'h11}));
        step();
`ifdef ALU_SCHED_RR_EN
        exp_g2 = 2'b10; exp_id2 = 1'b1; exp_d2 = 32'h1E;
`else
        exp_g2 = 2'b01; exp_id2 = 1'b0; exp_d2 = 32'h11;
`endif
        check("conflict_grant2", 80'(req_ready), 80'(exp_g2));
        step();
        step();
        step();
        check("conflict_rsp2", 80'({rsp_valid, rsp_id, rsp_data}), 80'({1'b1, exp_id2, exp_d2}));
        req_valid = 2'b00;
        step();

        // Response stall with both requesters waiting.
        req_a     = {16'h5555, 16'h0F0F};
        req_b     = {16'h3333, 16'h00FF};
        req_func  = {4'b0000, 4'b0110};
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #1;
        check("stall_grant", 80'(req_ready), 80'(2'b01));
        step();
        step();
        step();
        force_low = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("stall_hold", 80'({rsp_valid, req_ready, rsp_id, rsp_carry, rsp_err, rsp_data}),
                  80'({1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0FF0}));
            step();
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        #1;
        check("stall_release_valid", 80'(rsp_valid), 80'd1);
        step();
        check("stall_handshake", 80'(rsp_valid), 80'd0);
        force_low = 1'b0;

        // Reset asserted while the operation is in EXEC.
        req_a     = {16'hAAAA, 16'h0005};
        req_b     = {16'hBBBB, 16'h0006};
        req_func  = {4'b0101, 4'b0000};
        req_valid = 2'b01;
        #1;
        check("rst_test_grant", 80'(req_ready), 80'(2'b01));
        step();
        req_valid = 2'b00;
        #2 rst = 1'b0;
        #1;
        check("mid_reset_outputs",
              {req_ready, rsp_valid, rsp_id, rsp_carry, rsp_err, rsp_data, alu_a, alu_b, alu_func,
               6'b0}, 80'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        late_valid = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (rsp_valid) late_valid++;
        end
        check("no_orphan_rsp", 80'(late_valid), 80'd0);
        req_valid = 2'b11;
        #1;
        check("post_reset_grant", 80'(req_ready), 80'(2'b01));
        req_valid = 2'b00;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
